ts_pkt_sync: RTL

Downstream stage of the byte deinterleaver's per-stream TS read port: one instance per stream (ts0, ts1). On each `ts_int` it drains a frame of deinterleaved bytes with a credit-controlled `ts_en_rd` read loop into a small FIFO. It then hunts and locks onto the 0x47 MPEG-TS sync byte and emits aligned 188-byte packets on a valid/ready stream, with per-packet error flagging and lock status.

---
 rtl/ts_pkt_sync.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ts_pkt_sync.sv
// Per-stream TS read loop and 0x47 sync hunter: credit-paced reads into a skid FIFO, aligned 188-byte packets out.
// Latency: FIFO byte to pkt_valid 1 cycle; pkt_rdy low freezes the output register and FIFO pops, and a full FIFO stops ts_en_rd.

module ts_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 dout,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wr_d  = push ? wr_q + AW'(1) : wr_q;
        rd_d  = pop  ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (!push && pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
endmodule

module ts_pkt_sync #(
    parameter int FIFO_DEPTH = 8,
    parameter int LOCK_N     = 3,
    parameter int UNLOCK_N   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [16:0] frm_len,
    input  logic        ts_int,
    input  logic        ts_overflow,
    output logic        ts_en_rd,
    input  logic        ts_en_out,
    input  logic [7:0]  ts_dout,
    input  logic        pkt_rdy,
    output logic        pkt_valid,
    output logic [7:0]  pkt_data,
    output logic        pkt_sop,
    output logic        pkt_eop,
    output logic        pkt_err,
    output logic        lock,
    output logic        int_lost,
    output logic [15:0] pkt_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam logic [CW:0] DEPTH_C  = FIFO_DEPTH[CW:0];
    localparam logic [3:0]  LOCK_C   = LOCK_N[3:0];
    localparam logic [3:0]  UNLOCK_C = UNLOCK_N[3:0];

    typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} st_e;

    logic [1:0]    pend_q, pend_d;
    logic          int_lost_q, int_lost_d;
    logic          active_q, active_d;
    logic [16:0]   rem_q, rem_d;
    logic [CW-1:0] infl_q, infl_d;
    logic          ovf_q, ovf_d;
    st_e           st_q, st_d;
    logic [7:0]    bidx_q, bidx_d;
    logic [3:0]    good_q, good_d, bad_q, bad_d;
    logic          leave_q, leave_d, open_q, open_d, term_q, term_d;
    logic          vld_q, vld_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d, lock_q, lock_d;
    logic [7:0]    dat_q, dat_d;
    logic [15:0]   cnt_q, cnt_d;

    logic          start, rd_en, ret, int_inc, ovf_rise, pop, is_sync;
    logic          fwd, f_sop, f_eop, f_err;
    logic [CW:0]   credit_sum;
    logic [7:0]    next_bidx;
    logic [7:0]    fifo_dout;
    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt;

    ts_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (ret),
        .din   (ts_dout),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_comb begin
        start      = !active_q && (pend_q != 2'd0);
        credit_sum = {1'b0, fifo_cnt} + {1'b0, infl_q};
        rd_en      = active_q && (rem_q != '0) && (credit_sum < DEPTH_C);
        // Returns outside a session (e.g. stale bytes after reset) are dropped.
        ret        = ts_en_out && active_q && (infl_q != '0);
        int_inc    = ts_int && (frm_len != '0);

        pend_d     = pend_q;
        int_lost_d = int_lost_q;
        if (int_inc && !start) begin
            if (pend_q == 2'd3) int_lost_d = 1'b1;
            else                pend_d     = pend_q + 2'd1;
        end else if (!int_inc && start) begin
            pend_d = pend_q - 2'd1;
        end

        active_d = active_q;
        rem_d    = rem_q;
        if (start) begin
            active_d = 1'b1;
            rem_d    = frm_len;
        end else begin
            if (rd_en) rem_d = rem_q - 17'd1;
            if (rem_q == '0 && infl_q == '0) active_d = 1'b0;
        end

        infl_d = infl_q;
        if (rd_en && !ret)      infl_d = infl_q + CW'(1);
        else if (!rd_en && ret) infl_d = infl_q - CW'(1);

        vld_d = vld_q; dat_d = dat_q; sop_d = sop_q; eop_d = eop_q; err_d = err_q;
        cnt_d = cnt_q;
        if (vld_q && pkt_rdy) begin
            if (eop_q) cnt_d = cnt_q + 16'd1;
            vld_d = 1'b0; sop_d = 1'b0; eop_d = 1'b0; err_d = 1'b0;
        end

        ovf_d     = ts_overflow;
        ovf_rise  = ts_overflow && !ovf_q;
        pop       = !fifo_empty && (!vld_q || pkt_rdy) && !ovf_rise;
        is_sync   = (fifo_dout == 8'h47);
        next_bidx = (bidx_q == 8'd187) ? 8'd0 : bidx_q + 8'd1;

        st_d = st_q; bidx_d = bidx_q; good_d = good_q; bad_d = bad_q;
        leave_d = leave_q; open_d = open_q; term_d = term_q;
        fwd = 1'b0; f_sop = 1'b0; f_eop = 1'b0; f_err = 1'b0;

        if (ovf_rise) begin
            st_d = ST_HUNT; bidx_d = '0; good_d = '0; bad_d = '0;
            leave_d = 1'b0; open_d = 1'b0;
            term_d  = open_q;
        end else if (pop) begin
            if (term_q) begin
                // Close the packet cut short by the overflow with the next byte.
                fwd = 1'b1; f_eop = 1'b1; term_d = 1'b0;
            end else begin
                case (st_q)
                    ST_HUNT: begin
                        if (is_sync) begin
                            bidx_d = 8'd1; good_d = 4'd1; st_d = ST_VERIFY;
                        end
                    end
                    ST_VERIFY: begin
                        if (bidx_q == 8'd0) begin
                            if (is_sync) begin
                                good_d = good_q + 4'd1;
                                bidx_d = 8'd1;
                                if (good_q + 4'd1 >= LOCK_C) begin
                                    st_d = ST_LOCKED; bad_d = '0; leave_d = 1'b0;
                                    fwd = 1'b1; f_sop = 1'b1; open_d = 1'b1;
                                end
                            end else begin
                                st_d = ST_HUNT;
                            end
                        end else begin
                            bidx_d = next_bidx;
                        end
                    end
                    ST_LOCKED: begin
                        fwd    = 1'b1;
                        f_sop  = (bidx_q == 8'd0);
                        f_eop  = (bidx_q == 8'd187);
                        f_err  = (bidx_q == 8'd0) && !is_sync;
                        open_d = (bidx_q != 8'd187);
                        bidx_d = next_bidx;
                        if (bidx_q == 8'd0) begin
                            bad_d   = is_sync ? 4'd0 : bad_q + 4'd1;
                            leave_d = !is_sync && (bad_q + 4'd1 >= UNLOCK_C);
                        end
                        if (bidx_q == 8'd187 && leave_q) begin
                            st_d = ST_HUNT; leave_d = 1'b0;
                        end
                    end
                    default: st_d = ST_HUNT;
                endcase
            end
        end

        if (fwd) begin
            vld_d = 1'b1; dat_d = fifo_dout; sop_d = f_sop; eop_d = f_eop; err_d = f_err;
        end
        lock_d = (st_d == ST_LOCKED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0; int_lost_q <= 1'b0; active_q <= 1'b0; rem_q <= '0; infl_q <= '0;
            ovf_q <= 1'b0; st_q <= ST_HUNT; bidx_q <= '0; good_q <= '0; bad_q <= '0;
            leave_q <= 1'b0; open_q <= 1'b0; term_q <= 1'b0;
            vld_q <= 1'b0; dat_q <= '0; sop_q <= 1'b0; eop_q <= 1'b0; err_q <= 1'b0;
            lock_q <= 1'b0; cnt_q <= '0;
        end else begin
            pend_q <= pend_d; int_lost_q <= int_lost_d; active_q <= active_d;
            rem_q <= rem_d; infl_q <= infl_d;
            ovf_q <= ovf_d; st_q <= st_d; bidx_q <= bidx_d; good_q <= good_d; bad_q <= bad_d;
            leave_q <= leave_d; open_q <= open_d; term_q <= term_d;
            vld_q <= vld_d; dat_q <= dat_d; sop_q <= sop_d; eop_q <= eop_d; err_q <= err_d;
            lock_q <= lock_d; cnt_q <= cnt_d;
        end
    end

    assign ts_en_rd  = rd_en;
    assign pkt_valid = vld_q;
    assign pkt_data  = dat_q;
    assign pkt_sop   = sop_q;
    assign pkt_eop   = eop_q;
    assign pkt_err   = err_q;
    assign lock      = lock_q;
    assign int_lost  = int_lost_q;
    assign pkt_cnt   = cnt_q;
endmodule
